eeg_timing_gen: RTL and testbench

Timing and preamble generator for the ear-EEG acquisition front end. It derives the five chip control clocks (fadc_G, fch_G, READ_G, LOAD_G, fdata_G) from the 200 MHz system clock. It tracks the right/left channel selection. It serially emits an 8-bit PREVIN code on a trigger. It sits between the trigger/reset conditioning logic and the output sync register of the prototype top level.

---
 rtl/eeg_timing_gen.sv | 188 ++++++++++++++++++
 tb/tb_eeg_timing_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_timing_gen.sv
// Ear-EEG control clock, R/L select and serial PREVIN generator.
// Optional macro EEG_PREVIN_PARITY_EN appends an even-parity bit to PREVIN.
module eeg_timing_gen #(
  parameter int FDATA_DIV    = 100,
  parameter int BITS_PER_CH  = 16,
  parameter int CH_PER_FRAME = 8
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       R_L_con,
  input  logic       previn_trig,
  input  logic [7:0] previn_code,
  output logic [4:0] new_clks,
  output logic       R_L_state,
  output logic       previn
);

  localparam int DW = $clog2(FDATA_DIV);
  localparam int BW = $clog2(BITS_PER_CH);
  localparam int CW = $clog2(CH_PER_FRAME);
`ifdef EEG_PREVIN_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_SHIFT
  } state_t;

  logic          r_run;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic [CW-1:0] r_ch;
  logic [4:0]    r_clks;
  logic          r_rl_s1;
  logic          r_rl_s2;
  logic          r_rls;
  logic          r_tr_s1;
  logic          r_tr_s2;
  logic          r_tr_s3;
  state_t        r_state;
  logic [NB-1:0] r_sr;
  logic [LW-1:0] r_left;
  logic          r_previn;

  logic          w_div_wrap;
  logic          w_bit_wrap;
  logic          w_ch_wrap;
  logic          w_strobe;
  logic          w_frame;
  logic          w_qual;
  logic          w_trig_edge;
  logic [4:0]    w_clks;
  logic [NB-1:0] w_load;
  state_t        w_state_nxt;
  logic [NB-1:0] w_sr_nxt;
  logic [LW-1:0] w_left_nxt;
  logic          w_previn_nxt;

  assign w_div_wrap = (r_div == DW'(FDATA_DIV - 1));
  assign w_bit_wrap = (r_bit == BW'(BITS_PER_CH - 1));
  assign w_ch_wrap  = (r_ch == CW'(CH_PER_FRAME - 1));

  // r_run holds the chain at 0 for the first edge after release
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_div <= '0;
      r_bit <= '0;
      r_ch  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_div_wrap) begin
          r_div <= '0;
          if (w_bit_wrap) begin
            r_bit <= '0;
            r_ch  <= w_ch_wrap ? '0 : r_ch + 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign w_strobe = r_run & (r_div == '0);
  assign w_frame  = w_strobe & (r_bit == '0) & (r_ch == '0);

  assign w_clks = {
    (r_ch < CW'(CH_PER_FRAME / 2)),
    (r_bit < BW'(BITS_PER_CH / 2)),
    w_ch_wrap & w_bit_wrap,
    (r_ch == '0) & (r_bit == '0),
    (r_div < DW'(FDATA_DIV / 2))
  };

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_clks  <= '0;
      r_rl_s1 <= 1'b0;
      r_rl_s2 <= 1'b0;
      r_rls   <= 1'b0;
      r_tr_s1 <= 1'b0;
      r_tr_s2 <= 1'b0;
      r_tr_s3 <= 1'b0;
    end else begin
      if (r_run) r_clks <= w_clks;
      r_rl_s1 <= R_L_con;
      r_rl_s2 <= r_rl_s1;
      if (w_frame) r_rls <= r_rl_s2;
      r_tr_s1 <= previn_trig;
      r_tr_s2 <= r_tr_s1;
      r_tr_s3 <= r_tr_s2;
    end
  end

  assign w_trig_edge = r_tr_s2 & ~r_tr_s3;
  assign w_qual      = w_strobe & r_rls;

`ifdef EEG_PREVIN_PARITY_EN
  assign w_load = {previn_code, ^previn_code};
`else
  assign w_load = previn_code;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_sr_nxt     = r_sr;
    w_left_nxt   = r_left;
    w_previn_nxt = r_previn;
    unique case (r_state)
      S_IDLE: begin
        w_previn_nxt = 1'b0;
        if (w_trig_edge) begin
          w_sr_nxt    = w_load;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_qual) begin
          w_previn_nxt = r_sr[NB-1];
          w_sr_nxt     = r_sr << 1;
          w_left_nxt   = LW'(NB - 1);
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_qual) begin
          if (r_left == '0) begin
            w_previn_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_previn_nxt = r_sr[NB-1];
            w_sr_nxt     = r_sr << 1;
            w_left_nxt   = r_left - 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sr     <= '0;
      r_left   <= '0;
      r_previn <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sr     <= w_sr_nxt;
      r_left   <= w_left_nxt;
      r_previn <= w_previn_nxt;
    end
  end

  assign new_clks  = r_clks;
  assign R_L_state = r_rls;
  assign previn    = r_previn;

endmodule

// File: tb/tb_eeg_timing_gen.sv
// Scoreboard bench for eeg_timing_gen: arithmetic reference model,
// per-cycle expected outputs queued and checked by a negedge monitor.
`timescale 1ns/100ps
module tb_eeg_timing_gen;

  localparam int FD    = 100;
  localparam int BPC   = 16;
  localparam int CPF   = 8;
  localparam int FRAME = FD * BPC * CPF;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rl    = 1'b0;
  logic       trig  = 1'b0;
  logic [7:0] code  = 8'h00;
  logic [4:0] new_clks;
  logic       rls;
  logic       previn;

  eeg_timing_gen #(
    .FDATA_DIV   (FD),
    .BITS_PER_CH (BPC),
    .CH_PER_FRAME(CPF)
  ) dut (
    .sys_clk    (clk),
    .rst_n      (rst_n),
    .R_L_con    (rl),
    .previn_trig(trig),
    .previn_code(code),
    .new_clks   (new_clks),
    .R_L_state  (rls),
    .previn     (previn)
  );

  always #2.5 clk = ~clk;

  typedef struct packed {
    logic [4:0] clks;
    logic       rls;
    logic       prev;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int       m_t;
  bit       m_rls, m_prev, m_busy;
  bit [4:0] m_clks;
  bit       m_rl_d1, m_rl_d2, m_tr_d1, m_tr_d2, m_tr_d3;
  bit       m_bits[$];
  int       m_sent;

  always @(posedge clk) begin : model
    int   c, d, b, ch;
    bit   strobe, fs, acc, qual;
    exp_t e;
    if (!rst_n) begin
      m_t = 0; m_rls = 0; m_prev = 0; m_busy = 0; m_clks = '0;
      m_rl_d1 = 0; m_rl_d2 = 0;
      m_tr_d1 = 0; m_tr_d2 = 0; m_tr_d3 = 0;
      m_bits.delete(); m_sent = 0;
    end else begin
      m_t++;
      strobe = 0;
      fs = 0;
      if (m_t >= 2) begin
        c  = (m_t - 2) % FRAME;
        d  = c % FD;
        b  = (c / FD) % BPC;
        ch = c / (FD * BPC);
        strobe = (d == 0);
        fs = (c == 0);
        m_clks = {ch < CPF / 2, b < BPC / 2,
                  (ch == CPF - 1) && (b == BPC - 1),
                  (ch == 0) && (b == 0), d < FD / 2};
      end
      acc  = m_tr_d2 && !m_tr_d3;
      qual = strobe && m_rls;
      if (!m_busy) begin
        m_prev = 0;
        if (acc) begin
          for (int i = 7; i >= 0; i--) m_bits.push_back(code[i]);
`ifdef EEG_PREVIN_PARITY_EN
          m_bits.push_back(^code);
`endif
          m_busy = 1;
          m_sent = 0;
        end
      end else if (qual) begin
        if (m_bits.size() > 0) begin
          m_prev = m_bits.pop_front();
          m_sent++;
        end else begin
          m_prev = 0;
          m_busy = 0;
        end
      end
      if (fs) m_rls = m_rl_d2;
      m_rl_d2 = m_rl_d1; m_rl_d1 = rl;
      m_tr_d3 = m_tr_d2; m_tr_d2 = m_tr_d1; m_tr_d1 = trig;
    end
    e = '{m_clks, m_rls, m_prev};
    sb_q.push_back(e);
  end

  int       cyc = 0;
  int       last_rise[3];
  logic [4:0] prev_clks = '0;
  int       pos_of[3] = '{0, 3, 4};
  int       per_of[3] = '{FD, FD * BPC, FRAME};

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if ({new_clks, rls, previn} !== e) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got clks=%b rl=%b prev=%b want clks=%b rl=%b prev=%b",
                 cyc, new_clks, rls, previn, e.clks, e.rls, e.prev);
      end
    end
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) last_rise[k] = -1;
      prev_clks = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (new_clks[pos_of[k]] && !prev_clks[pos_of[k]]) begin
          if (last_rise[k] >= 0) begin
            vectors++;
            if (cyc - last_rise[k] != per_of[k]) begin
              miscompares++;
              $display("FAIL period clk%0d got %0d want %0d",
                       pos_of[k], cyc - last_rise[k], per_of[k]);
            end
          end
          last_rise[k] = cyc;
        end
      end
      prev_clks = new_clks;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] c);
    code = c;
    trig = 1'b1;
    wait_cyc($urandom_range(4, 12));
    trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (m_busy && n < budget) begin
      wait_cyc(1);
      n++;
    end
    if (m_busy) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout %s got busy after %0d cycles want idle", name, n);
    end
  endtask

  task automatic wait_sent(input int cnt, input int budget, input string name);
    int n = 0;
    while (m_sent < cnt && n < budget) begin
      wait_cyc(1);
      n++;
    end
    if (m_sent < cnt) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout %s got %0d bits want %0d", name, m_sent, cnt);
    end
  endtask

  initial begin
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(1000 + $urandom_range(0, 200));
    pulse(8'hFF);
    wait_cyc(4000 + $urandom_range(0, 500));
    rl = 1'b1;
    wait_sent(3, 20000, "ff_start");
    pulse(8'h00);
    wait_idle(5000, "ff_done");
    wait_cyc(200 + $urandom_range(0, 100));
    pulse(8'hA5);
    wait_idle(5000, "a5_done");
    for (int i = 0; i < 6; i++) begin
      wait_cyc($urandom_range(50, 600));
      if ($urandom_range(0, 3) == 0) rl = ~rl;
      pulse(8'($urandom_range(0, 255)));
      wait_cyc($urandom_range(0, 1200));
    end
    rl = 1'b1;
    wait_idle(30000, "rand_done");
    wait_cyc(100);
    pulse(8'($urandom_range(0, 255)));
    wait_sent(5, 30000, "abort_bit3");
    wait_cyc(30);
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(50);
    pulse(8'h07);
    wait_idle(30000, "code07_done");
    wait_cyc(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
